// File: rtl/cnt_cmp_pkg.sv
// Shared types and default widths for the counter/comparator run sequencer.
package cnt_cmp_pkg;

  localparam int CW_DEF    = 17;
  localparam int NW_DEF    = 16;
  localparam int HW_DEF    = 16;
  localparam int DRAIN_DEF = 2;

  // res_first value reported when a run saw no hit at all
  localparam logic [NW_DEF-1:0] NO_HIT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, otherwise step up unless already pinned at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_cmp_seq.sv
// Run sequencer: loads a compare word, settles, enables the datapath for a
// programmed number of cycles, drains, and reports hit count / first hit.
module cnt_cmp_seq
  import cnt_cmp_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int NW    = NW_DEF,
  parameter int HW    = HW_DEF,
  parameter int DRAIN = DRAIN_DEF
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          start,
  output logic          ready,
  input  logic          abort,
  input  logic [CW-1:0] cfg_c,
  input  logic [NW-1:0] cfg_cycles,
  input  logic [3:0]    cfg_settle,
  output logic          dp_p0,
  output logic [CW-1:0] dp_c,
  input  logic          dp_z,
  output logic          res_valid,
  input  logic          res_ack,
  output logic [HW-1:0] res_hits,
  output logic [NW-1:0] res_first,
  output logic          res_aborted
);

  localparam logic [3:0] DrainLast = 4'(DRAIN - 1);

  state_e        state_q, state_d;
  logic [3:0]    settle_q, settle_d;
  logic [NW-1:0] run_q, run_d;
  logic [3:0]    drain_q, drain_d;
  logic          dpP0_q, dpP0_d;
  logic [CW-1:0] dpC_q, dpC_d;
  logic [NW-1:0] first_q, first_d;
  logic          aborted_q, aborted_d;

  logic          accept;
  logic          sampling;
  logic          hitInc;
  logic [HW-1:0] hitCnt;
  logic [NW-1:0] idxCnt;

  // Next-state logic: phase sequencing, abort handling and first-hit capture
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    run_d     = run_q;
    drain_d   = drain_q;
    dpC_d     = dpC_q;
    first_d   = first_q;
    aborted_d = aborted_q;
    accept    = 1'b0;
    sampling  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          dpC_d     = cfg_c;
          settle_d  = cfg_settle;
          run_d     = cfg_cycles;
          first_d   = '1;
          aborted_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          drain_d   = DrainLast;
          state_d   = ST_DRAIN;
        end else if (settle_q == 4'd0) begin
          if (run_q == '0) begin
            drain_d = DrainLast;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_RUN: begin
        sampling = 1'b1;
        run_d    = run_q - NW'(1);
        if (abort) begin
          aborted_d = 1'b1;
          drain_d   = DrainLast;
          state_d   = ST_DRAIN;
        end else if (run_q == NW'(1)) begin
          drain_d = DrainLast;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        sampling = 1'b1;
        if (drain_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (res_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (sampling && dp_z && (hitCnt == '0)) begin
      first_d = idxCnt;
    end
  end

  assign hitInc = sampling & dp_z;
  assign dpP0_d = (state_d == ST_RUN);

  // State and result registers; reset drops the enable and returns to idle
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      run_q     <= '0;
      drain_q   <= '0;
      dpP0_q    <= 1'b0;
      dpC_q     <= '0;
      first_q   <= '1;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      run_q     <= run_d;
      drain_q   <= drain_d;
      dpP0_q    <= dpP0_d;
      dpC_q     <= dpC_d;
      first_q   <= first_d;
      aborted_q <= aborted_d;
    end
  end

  sat_cnt #(.W(HW)) uHits (
    .clk_i  (CK),
    .rst_ni (RN),
    .clr_i  (accept),
    .inc_i  (hitInc),
    .cnt_o  (hitCnt)
  );

  sat_cnt #(.W(NW)) uIndex (
    .clk_i  (CK),
    .rst_ni (RN),
    .clr_i  (accept),
    .inc_i  (sampling),
    .cnt_o  (idxCnt)
  );

  assign ready       = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign dp_p0       = dpP0_q;
  assign dp_c        = dpC_q;
  assign res_hits    = hitCnt;
  assign res_first   = first_q;
  assign res_aborted = aborted_q;

endmodule

// File: tb/tb_cnt_cmp_seq.sv
// Bench for cnt_cmp_seq: two instances (16-bit and 4-bit hit counters) share
// stimulus; each run's expected timeline is computed from its plan up front.
module tb_cnt_cmp_seq;
  import cnt_cmp_pkg::*;

  localparam int DRAIN_P = 2;

  logic        CK = 1'b0;
  logic        RN;
  logic        start, abort, res_ack, dp_z;
  logic [16:0] cfg_c;
  logic [15:0] cfg_cycles;
  logic [3:0]  cfg_settle;

  logic        readyA, dpP0A, resValidA, resAbortedA;
  logic [16:0] dpCA;
  logic [15:0] resHitsA, resFirstA;
  logic        readyB, dpP0B, resValidB, resAbortedB;
  logic [16:0] dpCB;
  logic [3:0]  resHitsB;
  logic [15:0] resFirstB;

  int total = 0;
  int bad   = 0;

  logic        checkEn, expReady, expP0, expValid, checkRes;
  logic [16:0] expC;
  logic [15:0] modelHits16, modelFirst;
  logic [3:0]  modelHits4;
  logic        modelAborted;
  int          curK, p0Seen, validSeen;
  bit          zByIdx [512];
  logic [15:0] lastHitsA, lastFirstA;
  logic [3:0]  lastHitsB;
  logic        lastAbortedA;
  logic [16:0] lastC;
  int          validAt, p0Cnt;

  cnt_cmp_seq #(.CW(17), .NW(16), .HW(16), .DRAIN(DRAIN_P)) dutA (
    .CK(CK), .RN(RN), .start(start), .ready(readyA), .abort(abort),
    .cfg_c(cfg_c), .cfg_cycles(cfg_cycles), .cfg_settle(cfg_settle),
    .dp_p0(dpP0A), .dp_c(dpCA), .dp_z(dp_z), .res_valid(resValidA),
    .res_ack(res_ack), .res_hits(resHitsA), .res_first(resFirstA),
    .res_aborted(resAbortedA)
  );

  cnt_cmp_seq #(.CW(17), .NW(16), .HW(4), .DRAIN(DRAIN_P)) dutB (
    .CK(CK), .RN(RN), .start(start), .ready(readyB), .abort(abort),
    .cfg_c(cfg_c), .cfg_cycles(cfg_cycles), .cfg_settle(cfg_settle),
    .dp_p0(dpP0B), .dp_c(dpCB), .dp_z(dp_z), .res_valid(resValidB),
    .res_ack(res_ack), .res_hits(resHitsB), .res_first(resFirstB),
    .res_aborted(resAbortedB)
  );

  always #5 CK = ~CK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare both instances against the current expectations
  always @(negedge CK) begin
    if (checkEn) begin
      checkOutput("readyA", 32'(readyA), 32'(expReady));
      checkOutput("readyB", 32'(readyB), 32'(expReady));
      checkOutput("p0A", 32'(dpP0A), 32'(expP0));
      checkOutput("p0B", 32'(dpP0B), 32'(expP0));
      checkOutput("validA", 32'(resValidA), 32'(expValid));
      checkOutput("validB", 32'(resValidB), 32'(expValid));
      checkOutput("dpcA", 32'(dpCA), 32'(expC));
      checkOutput("dpcB", 32'(dpCB), 32'(expC));
      if (checkRes) begin
        checkOutput("hitsA", 32'(resHitsA), 32'(modelHits16));
        checkOutput("hitsB", 32'(resHitsB), 32'(modelHits4));
        checkOutput("firstA", 32'(resFirstA), 32'(modelFirst));
        checkOutput("firstB", 32'(resFirstB), 32'(modelFirst));
        checkOutput("abortedA", 32'(resAbortedA), 32'(modelAborted));
        checkOutput("abortedB", 32'(resAbortedB), 32'(modelAborted));
      end
      if (dpP0A === 1'b1) p0Seen++;
      if (resValidA === 1'b1 && validSeen == 0) validSeen = curK;
    end
  end

  task automatic clearZ();
    for (int i = 0; i < 512; i++) zByIdx[i] = 1'b0;
  endtask

  // One run: s settle, n cycles, abortAt/resetAt as cycle offsets after accept (0 = none)
  task automatic applyStimulus(input int s, input int n, input int abortAt, input int resetAt,
                               input logic [16:0] c, output int vAt, output int pCnt);
    int activeEnd, winStart, winEnd, doneK, ackK, cnt, firstIdx;
    activeEnd = (abortAt != 0) ? abortAt : s + 1 + n;
    winStart  = (s + 2 < activeEnd + 1) ? s + 2 : activeEnd + 1;
    winEnd    = activeEnd + DRAIN_P;
    doneK     = winEnd + 1;
    ackK      = doneK + $urandom_range(0, 3);
    cnt = 0;
    firstIdx = -1;
    for (int i = 0; i <= winEnd - winStart; i++) begin
      if (zByIdx[i]) begin
        if (firstIdx < 0) firstIdx = i;
        cnt++;
      end
    end
    modelHits16  = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    modelHits4   = (cnt > 15) ? 4'hF : 4'(cnt);
    modelFirst   = (firstIdx < 0) ? NO_HIT : 16'(firstIdx);
    modelAborted = (abortAt != 0);

    cfg_c = c; cfg_settle = 4'(s); cfg_cycles = 16'(n);
    start = 1'b1; abort = 1'($urandom_range(0, 1)); res_ack = 1'b0;
    dp_z = 1'($urandom_range(0, 1));
    expReady = 1'b1; expP0 = 1'b0; expValid = 1'b0; checkRes = 1'b0;
    p0Seen = 0; validSeen = 0; curK = 0;
    @(posedge CK); #1;
    for (int k = 1; k <= ackK; k++) begin
      curK = k;
      start      = ($urandom_range(0, 3) == 0) || (k == ackK);
      abort      = (k == abortAt) || (k > activeEnd && $urandom_range(0, 1) == 1);
      dp_z       = (k >= winStart && k <= winEnd) ? zByIdx[k - winStart] : 1'($urandom_range(0, 1));
      res_ack    = (k == ackK) || (k < doneK && $urandom_range(0, 1) == 1);
      cfg_c      = 17'($urandom);
      cfg_cycles = 16'($urandom);
      cfg_settle = 4'($urandom);
      expReady = 1'b0;
      expP0    = (k >= s + 2 && k <= activeEnd);
      expValid = (k >= doneK);
      checkRes = (k >= doneK);
      expC     = c;
      if (k == resetAt) begin
        #1;
        start = 1'b0; abort = 1'b0; res_ack = 1'b0;
        RN = 1'b0;
        expReady = 1'b1; expP0 = 1'b0; expValid = 1'b0; expC = '0; checkRes = 1'b0;
        #1;
        checkOutput("rstImmReady", 32'(readyA), 32'd1);
        checkOutput("rstImmP0", 32'(dpP0A), 32'd0);
        @(negedge CK); #2;
        RN = 1'b1;
        break;
      end
      if (k == ackK) begin
        lastHitsA = resHitsA; lastHitsB = resHitsB; lastFirstA = resFirstA;
        lastAbortedA = resAbortedA; lastC = dpCA;
      end
      @(posedge CK); #1;
    end
    if (resetAt != 0) begin
      @(posedge CK); #1;
    end
    start = 1'b0; abort = 1'b0; res_ack = 1'b0;
    expReady = 1'b1; expP0 = 1'b0; expValid = 1'b0; checkRes = 1'b0;
    vAt  = validSeen;
    pCnt = p0Seen;
  endtask

  initial begin
    RN = 1'b0; start = 1'b0; abort = 1'b0; res_ack = 1'b0; dp_z = 1'b0;
    cfg_c = '0; cfg_cycles = '0; cfg_settle = '0;
    checkEn = 1'b0; expReady = 1'b1; expP0 = 1'b0; expValid = 1'b0;
    expC = '0; checkRes = 1'b0; curK = 0; p0Seen = 0; validSeen = 0;
    clearZ();
    repeat (2) @(posedge CK);
    #1;
    checkOutput("rstReady", 32'(readyA), 32'd1);
    checkOutput("rstP0", 32'(dpP0A), 32'd0);
    checkOutput("rstDpc", 32'(dpCA), 32'd0);
    checkOutput("rstValid", 32'(resValidA), 32'd0);
    checkOutput("rstHits", 32'(resHitsA), 32'd0);
    checkOutput("rstFirst", 32'(resFirstA), 32'hFFFF);
    checkOutput("rstAborted", 32'(resAbortedA), 32'd0);
    #2 RN = 1'b1;
    @(posedge CK); #1;
    checkEn = 1'b1;

    // basic run, no hits
    clearZ();
    applyStimulus(0, 5, 0, 0, 17'h00155, validAt, p0Cnt);
    checkOutput("t1P0Count", 32'(p0Cnt), 32'd5);
    checkOutput("t1ValidAt", 32'(validAt), 32'd9);
    checkOutput("t1Hits", 32'(lastHitsA), 32'd0);
    checkOutput("t1First", 32'(lastFirstA), 32'hFFFF);

    // hits at run indices 3 and 7
    clearZ(); zByIdx[3] = 1'b1; zByIdx[7] = 1'b1;
    applyStimulus(2, 10, 0, 0, 17'h1F00F, validAt, p0Cnt);
    checkOutput("t2Hits", 32'(lastHitsA), 32'd2);
    checkOutput("t2First", 32'(lastFirstA), 32'd3);
    checkOutput("t2Aborted", 32'(lastAbortedA), 32'd0);
    checkOutput("t2P0Count", 32'(p0Cnt), 32'd10);

    // zero-length run
    clearZ();
    applyStimulus(3, 0, 0, 0, 17'h1ABCD, validAt, p0Cnt);
    checkOutput("t3P0Count", 32'(p0Cnt), 32'd0);
    checkOutput("t3ValidAt", 32'(validAt), 32'd7);
    checkOutput("t3Dpc", 32'(lastC), 32'h1ABCD);
    checkOutput("t3Hits", 32'(lastHitsA), 32'd0);

    // abort at run index 4, hit in first drain cycle
    clearZ(); zByIdx[5] = 1'b1;
    applyStimulus(1, 100, 7, 0, 17'h00042, validAt, p0Cnt);
    checkOutput("t4Aborted", 32'(lastAbortedA), 32'd1);
    checkOutput("t4Hits", 32'(lastHitsA), 32'd1);
    checkOutput("t4First", 32'(lastFirstA), 32'd5);
    checkOutput("t4P0Count", 32'(p0Cnt), 32'd5);

    // z tied high: narrow counter saturates
    clearZ();
    for (int i = 0; i < 64; i++) zByIdx[i] = 1'b1;
    applyStimulus(0, 40, 0, 0, 17'h0AAAA, validAt, p0Cnt);
    checkOutput("t5HitsNarrow", 32'(lastHitsB), 32'hF);
    checkOutput("t5HitsWide", 32'(lastHitsA), 32'd42);
    checkOutput("t5First", 32'(lastFirstA), 32'd0);

    // reset at run index 2, then a normal run
    clearZ();
    applyStimulus(0, 20, 0, 4, 17'h12345, validAt, p0Cnt);
    checkOutput("t6Hits", 32'(resHitsA), 32'd0);
    checkOutput("t6First", 32'(resFirstA), 32'hFFFF);
    checkOutput("t6Valid", 32'(resValidA), 32'd0);
    clearZ(); zByIdx[0] = 1'b1;
    applyStimulus(1, 3, 0, 0, 17'h0F0F0, validAt, p0Cnt);
    checkOutput("t7ValidAt", 32'(validAt), 32'd8);
    checkOutput("t7P0Count", 32'(p0Cnt), 32'd3);
    checkOutput("t7First", 32'(lastFirstA), 32'd0);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      int s, n, ab;
      s = $urandom_range(0, 15);
      n = $urandom_range(0, 30);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, s + 1 + n) : 0;
      for (int i = 0; i < 512; i++) zByIdx[i] = ($urandom_range(0, 3) == 0);
      applyStimulus(s, n, ab, 0, 17'($urandom), validAt, p0Cnt);
    end

    repeat (3) @(posedge CK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
